// File: rtl/dmem_stage_bl_pkg.sv
// Shared opcodes, FSM state type and byte-lane helpers for the data-memory /
// write-back stage.
package dmem_stage_bl_pkg;

  localparam logic [5:0] OP_JAL  = 6'h03;
  localparam logic [5:0] OP_JALR = 6'h13;  // custom opcode carried over from the base datapath
  localparam logic [5:0] OP_LB   = 6'h20;
  localparam logic [5:0] OP_LH   = 6'h21;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_LBU  = 6'h24;
  localparam logic [5:0] OP_LHU  = 6'h25;
  localparam logic [5:0] OP_SB   = 6'h28;
  localparam logic [5:0] OP_SH   = 6'h29;
  localparam logic [5:0] OP_SW   = 6'h2b;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic is_load(input logic [5:0] op);
    return (op == OP_LB) || (op == OP_LBU) || (op == OP_LH) ||
           (op == OP_LHU) || (op == OP_LW);
  endfunction

  function automatic logic is_store(input logic [5:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic logic misaligned(input logic [5:0] op, input logic [1:0] off);
    logic bad;
    bad = 1'b0;
    case (op)
      OP_LH, OP_LHU, OP_SH: bad = off[0];
      OP_LW, OP_SW:         bad = |off;
      default:              bad = 1'b0;
    endcase
    return bad;
  endfunction

  // Big-endian lanes: be[3] is byte offset 0 (bits 31:24).
  function automatic logic [3:0] store_be(input logic [5:0] op, input logic [1:0] off);
    logic [3:0] be;
    be = 4'b0000;
    case (op)
      OP_SB:   be = 4'b1000 >> off;
      OP_SH:   be = off[1] ? 4'b0011 : 4'b1100;
      OP_SW:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Replicate the narrow store data so every enabled lane sees its bytes.
  function automatic logic [31:0] store_data(input logic [5:0] op, input logic [31:0] rt);
    logic [31:0] d;
    case (op)
      OP_SB:   d = {4{rt[7:0]}};
      OP_SH:   d = {2{rt[15:0]}};
      default: d = rt;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] load_extract(input logic [5:0] op, input logic [31:0] word,
                                               input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    h = off[1] ? word[15:0] : word[31:16];
    case (op)
      OP_LB:   r = {{24{b[7]}}, b};
      OP_LBU:  r = {24'd0, b};
      OP_LH:   r = {{16{h[15]}}, h};
      OP_LHU:  r = {16'd0, h};
      default: r = word;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dmem_stage_bl_if.sv
// Pipeline-side bus of the data-memory stage: request inputs and write-back outputs.
interface dmem_stage_bl_if;
  logic        req_valid;
  logic [31:0] Ins;
  logic [31:0] Result;
  logic [31:0] Rdata2;
  logic [31:0] nextPC;
  logic [31:0] Wdata;
  logic        wb_valid;
  logic        stall;
  logic        misalign;
  logic [31:0] SW_TEST;

  modport master (
    output req_valid, Ins, Result, Rdata2, nextPC,
    input  Wdata, wb_valid, stall, misalign, SW_TEST
  );

  modport slave (
    input  req_valid, Ins, Result, Rdata2, nextPC,
    output Wdata, wb_valid, stall, misalign, SW_TEST
  );
endinterface

// File: rtl/dmem_stage_bl_be_ram.sv
// DEPTH x 32 data memory: byte-enable synchronous write, two combinational reads.
module dmem_stage_bl_be_ram #(
  parameter int          DEPTH    = 256,
  parameter logic [31:0] INIT_VAL = 32'd777,
  localparam int         AW       = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic [3:0]    be_i,
  input  logic [AW-1:0] wr_idx_i,
  input  logic [31:0]   wr_data_i,
  input  logic [AW-1:0] rd_idx_a_i,
  input  logic [AW-1:0] rd_idx_b_i,
  output logic [31:0]   rd_data_a_o,
  output logic [31:0]   rd_data_b_o
);

  // Time-zero fill only; reset never clears memory.
  logic [31:0] mem_q [DEPTH] = '{default: INIT_VAL};

  // Per-lane write; be_i[3] is the most significant byte.
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < 4; b++) begin
      if (be_i[b]) mem_q[wr_idx_i][8*b +: 8] <= wr_data_i[8*b +: 8];
    end
  end

  assign rd_data_a_o = mem_q[rd_idx_a_i];
  assign rd_data_b_o = mem_q[rd_idx_b_i];

endmodule

// File: rtl/dmem_stage_bl.sv
// Data-memory / write-back stage: byte/half/word loads and stores with a
// fixed-latency load stall and misalignment drop.
//   state   | meaning
//   IDLE    | accepting; ALU/JAL write-back and stores finish here
//   BUSY    | load in flight, counting down remaining latency
//   DONE    | load data on Wdata for one cycle
module dmem_stage_bl
  import dmem_stage_bl_pkg::*;
#(
  parameter int          DEPTH    = 256,
  parameter int          RD_LAT   = 2,
  parameter logic [31:0] INIT_VAL = 32'd777
) (
  input logic           CLK,
  input logic           RST,
  dmem_stage_bl_if.slave bus
);

  localparam int         AW       = $clog2(DEPTH);
  localparam logic [1:0] CNT_INIT = (RD_LAT > 1) ? 2'(RD_LAT - 2) : 2'd0;

  state_t        state_q, state_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [AW+1:0] addr_q, addr_d;
  logic [5:0]    op_q, op_d;

  logic [5:0]  op;
  logic [3:0]  be;
  logic [31:0] wr_data;
  logic [31:0] ld_word;
  logic [31:0] wdata;
  logic        wb_valid, stall, misalign;
  logic        unused_bits;

  assign op          = bus.Ins[31:26];
  assign unused_bits = ^{bus.Ins[25:0], bus.Result[31:AW+2]};

  dmem_stage_bl_be_ram #(
    .DEPTH    (DEPTH),
    .INIT_VAL (INIT_VAL)
  ) u_ram (
    .clk_i       (CLK),
    .be_i        (be),
    .wr_idx_i    (bus.Result[AW+1:2]),
    .wr_data_i   (wr_data),
    .rd_idx_a_i  (addr_q[AW+1:2]),
    .rd_idx_b_i  (bus.Result[AW+1:2]),
    .rd_data_a_o (ld_word),
    .rd_data_b_o (bus.SW_TEST)
  );

  // Next state, store enables and write-back outputs; reset overrides everything.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    op_d     = op_q;
    be       = 4'b0000;
    wr_data  = '0;
    wdata    = '0;
    wb_valid = 1'b0;
    stall    = 1'b0;
    misalign = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          if (misaligned(op, bus.Result[1:0])) begin
            misalign = 1'b1;
          end else if (is_store(op)) begin
            be      = store_be(op, bus.Result[1:0]);
            wr_data = store_data(op, bus.Rdata2);
          end else if (is_load(op)) begin
            stall   = 1'b1;
            addr_d  = bus.Result[AW+1:0];
            op_d    = op;
            cnt_d   = CNT_INIT;
            state_d = (RD_LAT > 1) ? ST_BUSY : ST_DONE;
          end else begin
            wb_valid = 1'b1;
            wdata    = ((op == OP_JAL) || (op == OP_JALR)) ? bus.nextPC : bus.Result;
          end
        end
      end
      ST_BUSY: begin
        stall = 1'b1;
        if (cnt_q == 2'd0) state_d = ST_DONE;
        else               cnt_d   = cnt_q - 2'd1;
      end
      ST_DONE: begin
        wb_valid = 1'b1;
        wdata    = load_extract(op_q, ld_word, addr_q[1:0]);
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (RST) begin
      state_d  = ST_IDLE;
      be       = 4'b0000;
      wdata    = '0;
      wb_valid = 1'b0;
      stall    = 1'b0;
      misalign = 1'b0;
    end
  end

  // State, latency counter and latched load request.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      cnt_q   <= 2'd0;
      addr_q  <= '0;
      op_q    <= 6'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      op_q    <= op_d;
    end
  end

  assign bus.Wdata    = wdata;
  assign bus.wb_valid = wb_valid;
  assign bus.stall    = stall;
  assign bus.misalign = misalign;

endmodule

// File: doc/dmem_stage_bl.md
Name: dmem_stage_bl

Overview:
- Parametrised successor of the data-memory/write-back stage of the MIPS datapath. Sits after the ALU; its output drives the register-file write port.
- Adds byte and halfword loads and stores with sign/zero extension, and byte-enable writes.
- Adds a configurable read latency with a stall handshake, plus misalignment detection.
- Keeps the existing write-back selection: load data, return address for JAL/JALR, otherwise ALU result.

Parameters:
- DEPTH, 256, number of 32-bit words in data memory (power of two).
- RD_LAT, 2, load latency in cycles (1..4).
- INIT_VAL, 32'd777, time-zero fill value of every memory word (simulation init only).

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RST  in  1  synchronous, active-high reset.
- req_valid  in  1  stage holds a valid instruction this cycle.
- Ins  in  32  instruction; op = Ins[31:26].
- Result  in  32  ALU result; byte address for loads/stores.
- Rdata2  in  32  store data (rt).
- nextPC  in  32  PC+4, the return address.
- Wdata  out  32  write-back data.
- wb_valid  out  1  Wdata is valid for register write this cycle.
- stall  out  1  upstream must hold the instruction and inputs.
- misalign  out  1  one-cycle pulse: misaligned access, which was dropped.
- SW_TEST  out  32  debug: raw memory word at word index of Result, combinational.

Behaviour:
- Addressing:
  - Word index = Result[log2(DEPTH)+1:2]; upper bits are ignored, so addresses wrap modulo 4*DEPTH.
  - Byte order is big-endian: byte offset 0 is bits 31:24.
- Alignment: halfword ops need Result[0]=0; word ops need Result[1:0]=0.
- FSM states: IDLE, BUSY, DONE. Reset state is IDLE. Under reset, wb_valid=0, stall=0, misalign=0, Wdata=0. Memory contents are not cleared by RST.
- IDLE, non-memory op with req_valid:
  - wb_valid=1 in the same cycle.
  - Wdata = nextPC if op is JAL or JALR, else Result.
  - Both values are combinational.
- IDLE, store (SB/SH/SW) with req_valid, aligned:
  - Write takes effect at the next posedge.
  - Byte enables: SB writes lane Result[1:0] with Rdata2[7:0]. SH writes lanes {Result[1],0} and {Result[1],1} with Rdata2[15:0]. SW writes all 4 lanes.
  - No stall; wb_valid=0; FSM stays in IDLE.
- IDLE, load (LB/LBU/LH/LHU/LW) with req_valid, aligned:
  - stall=1 combinationally in the accept cycle.
  - Latch the address and op.
  - Go to BUSY if RD_LAT>1, else go to DONE.
- BUSY:
  - stall=1; a counter runs.
  - After RD_LAT-1 BUSY cycles in total, go to DONE.
  - Inputs are ignored; upstream holds them.
- DONE:
  - stall=0, wb_valid=1, Wdata = extracted and extended load data.
  - Next state is IDLE. The held request is not re-accepted.
  - Total: stall is high for RD_LAT cycles; data appears RD_LAT cycles after the accept edge.
- Load extraction:
  - LB: sign-extend the selected byte.
  - LBU: zero-extend the selected byte.
  - LH: sign-extend the selected halfword.
  - LHU: zero-extend the selected halfword.
  - LW: the whole word.
- Misaligned load or store:
  - No memory access; misalign=1 for that cycle.
  - wb_valid=0, stall=0; FSM stays in IDLE.
- req_valid=0 in IDLE: all outputs are 0 except SW_TEST.
- Read-after-write: a load accepted the cycle after a store to the same word returns the stored data. The load samples at or after the store's write edge.
- RST while BUSY or DONE:
  - Next state is IDLE; the pending load is aborted.
  - No wb_valid is produced for it.
  - Any store accepted in the same cycle as RST is not written.

Decomposition:
- common_param.vh gains LB 6'h20, LH 6'h21, LBU 6'h24, LHU 6'h25, SB 6'h28, SH 6'h29. It already carries LW, SW, JAL, JALR and DMEM_SIZE.
- FSM state encodings are local parameters.
- Sub-module dmem_be_ram:
  - DEPTH x 32 storage with a 4-bit byte-enable synchronous write and combinational read.
  - Initialised to INIT_VAL.
  - Feeds both the latched read path and SW_TEST.

Test Plan:
- Reset-then-read: after RST, LW at 0x10 with RD_LAT=2 -> stall high 2 cycles; DONE cycle Wdata=777, wb_valid=1.
- Byte/halfword store and load: SW 0x80FF1234 to 0x20, then SB 0xAB to 0x21 -> word=0x80AB1234. Then:
  - LB 0x21 -> 0xFFFFFFAB.
  - LBU 0x21 -> 0x000000AB.
  - LH 0x20 -> 0xFFFF80AB.
  - LHU 0x22 -> 0x00001234.
- Write-back mux: JAL with nextPC=0x400, Result=0x5 -> Wdata=0x400, wb_valid=1, no stall. ADD with Result=0x5 -> Wdata=0x5.
- Misalignment: LW at 0x22 -> misalign pulse, no stall, wb_valid=0. SH at 0x23 -> misalign pulse, and memory is unchanged (check via SW_TEST).
- Reset mid-load: RD_LAT=4, assert RST in the 2nd BUSY cycle -> FSM returns to IDLE, stall=0, no wb_valid. A following LW completes normally.
- Wrap-around: DEPTH=256, SW 0x55 to 0x400 -> LW 0x0 returns 0x55.
